// File: rtl/fleet_size_decider.sv
// rtl/fleet_size_decider.sv - ship-count negotiation controller for the battleship decision phase
// Collects per-player confirmed amounts, forces a decision on timeout, publishes the minimum under ready/ack.
module fleet_size_decider #(
  parameter int NUM_PLAYERS    = 2,
  parameter int CNT_W          = 3,
  parameter int MAX_SHIPS      = 5,
  parameter int DEFAULT_SHIPS  = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         decision,
  input  logic [NUM_PLAYERS*CNT_W-1:0] amount_in,
  input  logic [NUM_PLAYERS-1:0]       confirm,
  input  logic                         ack,
  output logic                         ships_decided,
  output logic [CNT_W-1:0]             agreed_amount,
  output logic [NUM_PLAYERS-1:0]       player_locked,
  output logic [NUM_PLAYERS-1:0]       invalid_pulse,
  output logic                         timed_out,
  output logic                         busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_AMT    = CNT_W'(MAX_SHIPS);
  localparam logic [CNT_W-1:0] DEF_AMT    = CNT_W'(DEFAULT_SHIPS);
  localparam logic [CNT_W-1:0] MIN_AMT    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [NUM_PLAYERS-1:0]       confirm_q, confirm_d;
  logic [TW-1:0]                timer_q, timer_d;
  logic [NUM_PLAYERS*CNT_W-1:0] amt_q, amt_d;
  logic [NUM_PLAYERS-1:0]       locked_q, locked_d;
  logic [NUM_PLAYERS-1:0]       invalid_q, invalid_d;
  logic [CNT_W-1:0]             agreed_q, agreed_d;
  logic                         decided_q, decided_d;
  logic                         timed_out_q, timed_out_d;

  logic [NUM_PLAYERS-1:0]       cfm_edge;
  logic [CNT_W-1:0]             req_amt;
  logic [CNT_W-1:0]             cand;
  logic [CNT_W-1:0]             min_amt;

  always_comb begin
    state_d     = state_q;
    confirm_d   = confirm;
    timer_d     = timer_q;
    amt_d       = amt_q;
    locked_d    = locked_q;
    invalid_d   = '0;
    agreed_d    = agreed_q;
    decided_d   = decided_q;
    timed_out_d = timed_out_q;
    cfm_edge    = confirm & ~confirm_q;
    req_amt     = '0;
    cand        = '0;
    min_amt     = '1;

    case (state_q)
      S_IDLE: begin
        if (decision) begin
          state_d     = S_COLLECT;
          locked_d    = '0;
          timer_d     = '0;
          agreed_d    = '0;
          timed_out_d = 1'b0;
        end
      end

      S_COLLECT: begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          req_amt = amount_in[i*CNT_W +: CNT_W];
          if (cfm_edge[i] && !locked_q[i]) begin
            if (req_amt >= MIN_AMT && req_amt <= MAX_AMT) begin
              amt_d[i*CNT_W +: CNT_W] = req_amt;
              locked_d[i]             = 1'b1;
            end else begin
              invalid_d[i] = 1'b1;
            end
          end
        end

        // Built from next-cycle lock state so a lock landing on the timeout edge still counts.
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          cand = locked_d[i] ? amt_d[i*CNT_W +: CNT_W] : DEF_AMT;
          if (cand < min_amt) begin
            min_amt = cand;
          end
        end

        if (!decision) begin
          state_d  = S_IDLE;
          locked_d = '0;
        end else if (&locked_q) begin
          state_d   = S_DONE;
          agreed_d  = min_amt;
          decided_d = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          state_d     = S_DONE;
          agreed_d    = min_amt;
          decided_d   = 1'b1;
          timed_out_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_DONE: begin
        if (ack) begin
          state_d   = S_IDLE;
          decided_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      confirm_q   <= '0;
      timer_q     <= '0;
      amt_q       <= '0;
      locked_q    <= '0;
      invalid_q   <= '0;
      agreed_q    <= '0;
      decided_q   <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      confirm_q   <= confirm_d;
      timer_q     <= timer_d;
      amt_q       <= amt_d;
      locked_q    <= locked_d;
      invalid_q   <= invalid_d;
      agreed_q    <= agreed_d;
      decided_q   <= decided_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign ships_decided = decided_q;
  assign agreed_amount = agreed_q;
  assign player_locked = locked_q;
  assign invalid_pulse = invalid_q;
  assign timed_out     = timed_out_q;
  assign busy          = (state_q == S_COLLECT);

endmodule

// File: tb/tb_fleet_size_decider.sv
// tb/tb_fleet_size_decider.sv - directed scoreboard bench for fleet_size_decider
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
module tb_fleet_size_decider;

  logic       clk = 1'b0;
  logic       rst;
  logic       decision;
  logic [5:0] amount_in;
  logic [1:0] confirm;
  logic       ack;
  logic       ships_decided;
  logic [2:0] agreed_amount;
  logic [1:0] player_locked;
  logic [1:0] invalid_pulse;
  logic       timed_out;
  logic       busy;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [2:0] amt;
    logic       to;
    logic [1:0] lk;
  } exp_t;

  exp_t sb_q[$];

  fleet_size_decider #(
    .NUM_PLAYERS(2), .CNT_W(3), .MAX_SHIPS(5), .DEFAULT_SHIPS(1), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .decision(decision), .amount_in(amount_in),
    .confirm(confirm), .ack(ack), .ships_decided(ships_decided),
    .agreed_amount(agreed_amount), .player_locked(player_locked),
    .invalid_pulse(invalid_pulse), .timed_out(timed_out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_amt(input int p, input logic [2:0] v);
    amount_in[p*3 +: 3] = v;
  endtask

  task automatic push_exp(input logic [2:0] amt, input logic to, input logic [1:0] lk);
    exp_t e;
    e.amt = amt;
    e.to  = to;
    e.lk  = lk;
    sb_q.push_back(e);
  endtask

  task automatic wait_decided(input string tag, input int budget);
    int   n;
    exp_t e;
    n = 0;
    while (!ships_decided && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, ships_decided, 1);
    chk({tag, "_sb_nonempty"}, (sb_q.size() != 0), 1);
    if (ships_decided && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_amount"}, agreed_amount, e.amt);
      chk({tag, "_timed_out"}, timed_out, e.to);
      chk({tag, "_locked"}, player_locked, e.lk);
    end
  endtask

  task automatic do_ack(input string tag);
    ack      = 1'b1;
    decision = 1'b0;
    cyc(1);
    chk({tag, "_ack_fall"}, ships_decided, 0);
    chk({tag, "_ack_idle"}, busy, 0);
    ack     = 1'b0;
    confirm = 2'b00;
    cyc(1);
  endtask

  initial begin
    rst       = 1'b1;
    decision  = 1'b0;
    amount_in = '0;
    confirm   = 2'b00;
    ack       = 1'b0;
    cyc(2);
    chk("rst_decided", ships_decided, 0);
    chk("rst_agreed", agreed_amount, 0);
    chk("rst_locked", player_locked, 0);
    chk("rst_invalid", invalid_pulse, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    ack = 1'b1;
    cyc(1);
    chk("idle_ack_ignored", busy, 0);
    ack = 1'b0;

    // 1: normal two-player agreement
    decision = 1'b1;
    cyc(1);
    chk("t1_busy", busy, 1);
    set_amt(0, 3'd3);
    confirm = 2'b01;
    cyc(1);
    chk("t1_lock01", player_locked, 2'b01);
    cyc(1);
    set_amt(1, 3'd4);
    confirm = 2'b11;
    push_exp(3'd3, 1'b0, 2'b11);
    cyc(1);
    chk("t1_lock11", player_locked, 2'b11);
    chk("t1_not_yet", ships_decided, 0);
    cyc(1);
    chk("t1_rise", ships_decided, 1);
    wait_decided("t1", 4);
    decision = 1'b0;
    cyc(3);
    chk("t1_hold", ships_decided, 1);
    chk("t1_hold_amt", agreed_amount, 3);
    ack = 1'b1;
    cyc(1);
    chk("t1_ack_fall", ships_decided, 0);
    chk("t1_idle", busy, 0);
    chk("t1_amt_kept", agreed_amount, 3);
    chk("t1_lock_kept", player_locked, 2'b11);
    ack     = 1'b0;
    confirm = 2'b00;
    cyc(1);

    // 2: illegal amounts pulse and do not lock
    decision = 1'b1;
    cyc(1);
    set_amt(0, 3'd0);
    confirm = 2'b01;
    cyc(1);
    chk("t2_inv0", invalid_pulse, 2'b01);
    chk("t2_nolock0", player_locked, 2'b00);
    cyc(1);
    chk("t2_inv0_end", invalid_pulse, 2'b00);
    confirm = 2'b00;
    set_amt(0, 3'd6);
    cyc(1);
    confirm = 2'b01;
    cyc(1);
    chk("t2_inv6", invalid_pulse, 2'b01);
    cyc(1);
    chk("t2_inv6_end", invalid_pulse, 2'b00);
    chk("t2_nolock6", player_locked, 2'b00);
    confirm = 2'b00;
    set_amt(0, 3'd2);
    cyc(1);
    confirm = 2'b01;
    cyc(1);
    chk("t2_lock2", player_locked, 2'b01);
    chk("t2_no_pulse", invalid_pulse, 2'b00);
    set_amt(1, 3'd5);
    confirm = 2'b11;
    push_exp(3'd2, 1'b0, 2'b11);
    wait_decided("t2", 6);
    do_ack("t2");

    // 3: timeout with one player missing
    decision = 1'b1;
    cyc(1);
    set_amt(0, 3'd4);
    confirm = 2'b01;
    push_exp(3'd1, 1'b1, 2'b01);
    cyc(1);
    chk("t3_lock01", player_locked, 2'b01);
    cyc(14);
    chk("t3_before_to", ships_decided, 0);
    chk("t3_busy", busy, 1);
    cyc(1);
    chk("t3_at_to", ships_decided, 1);
    wait_decided("t3", 1);
    do_ack("t3");

    // 4: held switch needs release; locked player cannot relock
    set_amt(1, 3'd2);
    confirm = 2'b10;
    cyc(1);
    decision = 1'b1;
    cyc(2);
    chk("t4_held_nolock", player_locked, 2'b00);
    set_amt(0, 3'd3);
    confirm = 2'b11;
    cyc(1);
    chk("t4_p0_lock", player_locked, 2'b01);
    confirm = 2'b10;
    cyc(1);
    set_amt(0, 3'd1);
    confirm = 2'b11;
    cyc(1);
    chk("t4_relock_ignored", player_locked, 2'b01);
    chk("t4_no_pulse", invalid_pulse, 2'b00);
    confirm = 2'b01;
    cyc(1);
    chk("t4_release", player_locked, 2'b01);
    confirm = 2'b11;
    push_exp(3'd2, 1'b0, 2'b11);
    cyc(1);
    chk("t4_lock11", player_locked, 2'b11);
    wait_decided("t4", 4);
    do_ack("t4");

    // 5: abort mid-collect, then a fresh round with restarted timer
    decision = 1'b1;
    cyc(1);
    set_amt(0, 3'd3);
    confirm = 2'b01;
    cyc(1);
    chk("t5_lock01", player_locked, 2'b01);
    cyc(5);
    decision = 1'b0;
    cyc(1);
    chk("t5_abort_idle", busy, 0);
    chk("t5_abort_clr", player_locked, 2'b00);
    chk("t5_abort_nodec", ships_decided, 0);
    confirm = 2'b00;
    cyc(3);
    chk("t5_still_nodec", ships_decided, 0);
    decision = 1'b1;
    push_exp(3'd1, 1'b1, 2'b00);
    cyc(1);
    chk("t5_reenter", busy, 1);
    cyc(15);
    chk("t5_before_to", ships_decided, 0);
    cyc(1);
    chk("t5_at_to", ships_decided, 1);
    wait_decided("t5", 1);
    do_ack("t5");

    // 6: simultaneous lock then asynchronous reset while waiting for ack
    decision = 1'b1;
    cyc(1);
    set_amt(0, 3'd5);
    set_amt(1, 3'd5);
    confirm = 2'b11;
    push_exp(3'd5, 1'b0, 2'b11);
    cyc(1);
    chk("t6_lock11", player_locked, 2'b11);
    wait_decided("t6", 4);
    rst = 1'b1;
    #1;
    chk("t6_rst_decided", ships_decided, 0);
    chk("t6_rst_agreed", agreed_amount, 0);
    chk("t6_rst_locked", player_locked, 0);
    chk("t6_rst_timed_out", timed_out, 0);
    chk("t6_rst_busy", busy, 0);
    @(negedge clk);
    rst      = 1'b0;
    decision = 1'b0;
    confirm  = 2'b00;
    cyc(1);
    chk("t6_after_rst_idle", busy, 0);

    // 7: lock captured on the timeout edge still counts
    decision = 1'b1;
    cyc(1);
    set_amt(0, 3'd3);
    confirm = 2'b01;
    cyc(1);
    confirm = 2'b00;
    cyc(14);
    chk("t7_not_yet", ships_decided, 0);
    set_amt(1, 3'd2);
    confirm = 2'b10;
    push_exp(3'd2, 1'b1, 2'b11);
    cyc(1);
    wait_decided("t7", 0);
    do_ack("t7");

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fleet_size_decider.md
Name: fleet_size_decider

Overview:
Parametrised ship-count negotiation controller for the battleship game's decision phase. It collects a confirmed ship amount from each of NUM_PLAYERS players using edge-detected confirm switches, and validates each amount against MAX_SHIPS. Missing players are filled with a default after a timeout. It then publishes one agreed amount, which is the minimum of all locked amounts. The result is held under a ready/ack handshake until the placement stage accepts it.

Parameters:
NUM_PLAYERS, 2, number of players/channels (1..8)
CNT_W, 3, width of each ship-amount field
MAX_SHIPS, 5, largest legal amount (1..2^CNT_W-1)
DEFAULT_SHIPS, 1, amount substituted for unlocked players on timeout (1..MAX_SHIPS)
TIMEOUT_CYCLES, 1024, clk cycles allowed in COLLECT before forced decision (>=2)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
decision  input  1  level; top-level FSM is in ship-decision state
amount_in  input  NUM_PLAYERS*CNT_W  per-player requested amount; player i at bits [i*CNT_W +: CNT_W]
confirm  input  NUM_PLAYERS  per-player confirm switch (level, synchronised upstream)
ack  input  1  downstream accepts agreed_amount
ships_decided  output  1  agreed_amount valid; held until ack
agreed_amount  output  CNT_W  min of locked amounts
player_locked  output  NUM_PLAYERS  player i has a valid locked amount
invalid_pulse  output  NUM_PLAYERS  1-cycle pulse: player i confirmed an illegal amount
timed_out  output  1  decision was forced by timeout; valid with ships_decided
busy  output  1  state is COLLECT

Behaviour:
- Reset: state IDLE. All outputs 0. confirm_q=0, timer=0, stored amounts=0.
- Edge detect: confirm_q <= confirm every cycle in all states. edge[i] = confirm[i] & ~confirm_q[i].
  - A switch already high when COLLECT is entered produces no edge; the player must release and re-press.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - decision=1 -> COLLECT next edge.
  - On entry to COLLECT: player_locked=0, timer=0, agreed_amount=0, timed_out=0.
- COLLECT:
  - busy=1. timer increments each cycle.
  - On edge[i] with player i unlocked:
    - If 1 <= amount_in[i] <= MAX_SHIPS: store the amount and set player_locked[i]=1 at that clock edge.
    - Otherwise: invalid_pulse[i]=1 for exactly one cycle; the player stays unlocked.
  - Edges from already-locked players are ignored (no relock, no pulse).
  - Several players may lock in the same cycle.
  - Transitions, priority top-down:
    1. decision=0 -> IDLE next edge. Clear player_locked; no ships_decided.
    2. Registered player_locked all ones -> DONE next edge. ships_decided rises 1 cycle after the last lock bit is visible.
    3. timer == TIMEOUT_CYCLES-1 -> DONE next edge with timed_out=1. A lock captured on this same edge still counts. Unlocked players contribute DEFAULT_SHIPS; player_locked is left as-is.
- Entry to DONE:
  - agreed_amount <= minimum over players of (locked ? stored : DEFAULT_SHIPS). This is an unsigned CNT_W compare.
  - ships_decided <= 1.
- DONE:
  - Outputs held stable. decision is ignored.
  - ack=1 -> IDLE next edge. ships_decided falls on that edge; agreed_amount, timed_out and player_locked hold until the next COLLECT entry.
  - ack while not in DONE is ignored.
- Timer width is clog2(TIMEOUT_CYCLES). It never wraps, because it is cleared on COLLECT entry and COLLECT exits at TIMEOUT_CYCLES-1.
- rst at any time returns to IDLE asynchronously with all outputs 0. No partial state survives.
- NUM_PLAYERS=1: the single lock immediately satisfies "all locked".

Test Plan:
All scenarios use NUM_PLAYERS=2, MAX_SHIPS=5, DEFAULT_SHIPS=1, TIMEOUT_CYCLES=16.
1. decision=1, P0 amount 3 confirm edge, P1 amount 4 confirm edge 2 cycles later -> player_locked 01 then 11; ships_decided=1 one cycle later; agreed_amount=3; timed_out=0; hold until ack, then IDLE.
2. P0 confirms amount 0, then amount 6 -> two invalid_pulse[0] single-cycle pulses; player_locked[0]=0. Then amount 2 confirm -> locks.
3. Only P0 locks 4, P1 never confirms -> after 16 COLLECT cycles ships_decided=1, timed_out=1, agreed_amount=1, player_locked=01.
4. P1 confirm held high before decision rises, amount 2 -> no lock. Release and re-press -> locks. P0 re-press after lock -> no change.
5. decision drops to 0 mid-COLLECT with P0 locked -> IDLE, player_locked=00, ships_decided never asserts. Next decision starts fresh, with timer restarted.
6. Both lock 5 simultaneously, then assert rst asynchronously while ships_decided=1 with ack=0 -> all outputs 0 immediately, state IDLE.
